countdown_128bit_sync_reset: RTL and testbench

Loadable 128-bit down-counting timer: software or upstream logic loads a count, starts it, and receives a one-cycle `done` pulse when it reaches terminal count. Optional auto-reload makes it a periodic tick generator. It is the consuming-side counterpart of the free-running up-counters in the counters suite and is used wherever a fixed number of cycles must elapse before an event.

---
 rtl/counter_pkg.sv | 18 +
 rtl/down_counter_core.sv | 42 ++++
 rtl/countdown_128bit_sync_reset.sv | 130 +++++++++++++
 tb/tb_countdown_128bit_sync_reset.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the down-counting timer: state encoding and default width.
package counter_pkg;

  localparam int COUNTER_WIDTH = 128;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RUN     = ST_RUN,
    PAUSE   = ST_PAUSE,
    EXPIRED = ST_EXPIRED
  } state_e;

endpackage

// File: rtl/down_counter_core.sv
// Plain WIDTH-bit down-counter datapath: load, decrement enable and terminal flags.
module down_counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dec_en,
  output logic [WIDTH-1:0] count,
  output logic             is_one,
  output logic             is_zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Saturate at zero so a stray decrement can never wrap to all-ones.
  always_comb begin
    count_d = count_q;
    if (load_en) begin
      count_d = load_data;
    end else if (dec_en && !is_zero) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_one  = (count_q == WIDTH'(1));
  assign is_zero = (count_q == '0);

endmodule

// File: rtl/countdown_128bit_sync_reset.sv
// Loadable down-counting timer with pause, auto-reload and a one-cycle done pulse.
module countdown_128bit_sync_reset
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;

  logic             core_load;
  logic [WIDTH-1:0] core_data;
  logic             core_dec;
  logic             is_one;
  logic             is_zero;
  logic             reload_nz;

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load_en   (core_load),
    .load_data (core_data),
    .dec_en    (core_dec),
    .count     (count),
    .is_one    (is_one),
    .is_zero   (is_zero)
  );

  assign reload_nz = |reload_q;

  // Priority is load > stop > start; a stop also masks a simultaneous start.
  always_comb begin
    state_d   = state_q;
    reload_d  = reload_q;
    done_d    = 1'b0;
    core_load = 1'b0;
    core_data = load_value;
    core_dec  = 1'b0;

    if (load) begin
      core_load = 1'b1;
      reload_d  = load_value;
      state_d   = IDLE;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (start) begin
            if (is_zero) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (is_zero) begin
            state_d = EXPIRED;
          end else if (is_one) begin
            done_d = 1'b1;
            if (auto_reload && reload_nz) begin
              core_load = 1'b1;
              core_data = reload_q;
            end else begin
              core_dec = 1'b1;
              state_d  = EXPIRED;
            end
          end else begin
            core_dec = 1'b1;
          end
        end
        EXPIRED: begin
          if (start) begin
            if (reload_nz) begin
              core_load = 1'b1;
              core_data = reload_q;
              state_d   = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d    = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      reload_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_128bit_sync_reset.sv
// Directed, table-driven bench for the 128-bit countdown timer plus multi-cycle corner sequences.
module tb_countdown_128bit_sync_reset;

   localparam int W = 128;

   logic         clk;
   logic         reset;
   logic         load;
   logic [W-1:0] load_value;
   logic         start;
   logic         stop;
   logic         auto_reload;
   logic [W-1:0] count;
   logic         busy;
   logic         done;
   logic         expired;

   int checks;
   int fails;

   typedef struct {
      logic         rst;
      logic         ld;
      logic [W-1:0] lv;
      logic         st;
      logic         sp;
      logic         ar;
      logic [W-1:0] ec;
      logic         eb;
      logic         ed;
      logic         ee;
   } vec_t;

   vec_t vecs[$];

   countdown_128bit_sync_reset dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .load_value  (load_value),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .expired     (expired)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, input logic ld, input logic [W-1:0] lv,
                               input logic st, input logic sp, input logic ar,
                               input logic [W-1:0] ec, input logic eb, input logic ed, input logic ee);
      vec_t v;
      v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.ar = ar;
      v.ec = ec; v.eb = eb; v.ed = ed; v.ee = ee;
      return v;
   endfunction

   // Drive one cycle of inputs, let the clock edge take them, then settle before sampling.
   task automatic applyStimulus(input logic rst, input logic ld, input logic [W-1:0] lv,
                                input logic st, input logic sp, input logic ar);
      reset       = rst;
      load        = ld;
      load_value  = lv;
      start       = st;
      stop        = sp;
      auto_reload = ar;
      @(posedge clk);
      #1;
   endtask

   // Compare every output against its expected value, one comparison per output.
   task automatic checkOutput(input string name, input logic [W-1:0] ec,
                              input logic eb, input logic ed, input logic ee);
      checks++;
      if (count !== ec) begin
         fails++;
         $display("[TB] FAIL %s count: got %h expected %h", name, count, ec);
      end
      checks++;
      if (busy !== eb) begin
         fails++;
         $display("[TB] FAIL %s busy: got %b expected %b", name, busy, eb);
      end
      checks++;
      if (done !== ed) begin
         fails++;
         $display("[TB] FAIL %s done: got %b expected %b", name, done, ed);
      end
      checks++;
      if (expired !== ee) begin
         fails++;
         $display("[TB] FAIL %s expired: got %b expected %b", name, expired, ee);
      end
   endtask

   initial begin
      logic [W-1:0] all_ones;
      checks      = 0;
      fails       = 0;
      all_ones    = '1;
      reset       = 1'b0;
      load        = 1'b0;
      load_value  = '0;
      start       = 1'b0;
      stop        = 1'b0;
      auto_reload = 1'b0;

      // Reset, basic countdown of 5, load 0 then start, start+stop priority, load on terminal cycle.
      //                rst ld  lv    st sp ar   count  busy done exp
      vecs.push_back(mk(0, 0, 128'd0, 0, 0, 0, 128'd0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 128'd0, 0, 0, 0, 128'd0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 128'd5, 0, 0, 0, 128'd5, 0, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 1, 0, 0, 128'd5, 1, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd4, 1, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd3, 1, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd2, 1, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd0, 0, 1, 1));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd0, 0, 0, 1));
      vecs.push_back(mk(1, 1, 128'd0, 0, 0, 0, 128'd0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 1, 0, 0, 128'd0, 0, 1, 1));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 128'd0, 1, 0, 0, 128'd0, 0, 1, 1));
      vecs.push_back(mk(1, 1, 128'd3, 0, 0, 0, 128'd3, 0, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 1, 0, 0, 128'd3, 1, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 1, 1, 0, 128'd3, 0, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 1, 1, 0, 128'd3, 0, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 1, 0, 0, 128'd3, 1, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd2, 1, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd1, 1, 0, 0));
      vecs.push_back(mk(1, 1, 128'd7, 0, 0, 0, 128'd7, 0, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 0, 0, 128'd7, 0, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 0, 1, 0, 128'd7, 0, 0, 0));
      vecs.push_back(mk(1, 0, 128'd0, 1, 1, 0, 128'd7, 0, 0, 0));

      $display("[TB] table phase: %0d vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].ar);
         checkOutput($sformatf("vec%0d", i), vecs[i].ec, vecs[i].eb, vecs[i].ed, vecs[i].ee);
      end

      // Auto-reload with N=3: count cycles 2,1,3 and done lands with every reload.
      $display("[TB] auto-reload sequence");
      applyStimulus(1, 1, 128'd3, 0, 0, 1);
      applyStimulus(1, 0, 128'd0, 1, 0, 1);
      checkOutput("ar_start", 128'd3, 1, 0, 0);
      for (int k = 1; k <= 9; k++) begin
         logic [W-1:0] ec;
         ec = (k % 3 == 0) ? 128'd3 : 128'(3 - (k % 3));
         applyStimulus(1, 0, 128'd0, 0, 0, 1);
         checkOutput($sformatf("ar_edge%0d", k), ec, 1, (k % 3 == 0), 0);
      end

      // Pause after 4 decrements from 10, hold 6 for 5 cycles, then resume to expiry.
      $display("[TB] pause/resume sequence");
      applyStimulus(1, 1, 128'd10, 0, 0, 0);
      applyStimulus(1, 0, 128'd0, 1, 0, 0);
      checkOutput("pr_start", 128'd10, 1, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1, 0, 128'd0, 0, 0, 0);
         checkOutput($sformatf("pr_dec%0d", k), 128'(10 - k), 1, 0, 0);
      end
      applyStimulus(1, 0, 128'd0, 0, 1, 0);
      checkOutput("pr_stop", 128'd6, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1, 0, 128'd0, 0, 0, 0);
         checkOutput($sformatf("pr_hold%0d", k), 128'd6, 0, 0, 0);
      end
      applyStimulus(1, 0, 128'd0, 1, 0, 0);
      checkOutput("pr_resume", 128'd6, 1, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1, 0, 128'd0, 0, 0, 0);
         checkOutput($sformatf("pr_run%0d", k), 128'(6 - k), (k < 6), (k == 6), (k == 6));
      end

      // Full-scale load counts down without wrapping; reset mid-run clears everything.
      $display("[TB] full-scale and reset sequence");
      applyStimulus(1, 1, all_ones, 0, 0, 0);
      checkOutput("fs_load", all_ones, 0, 0, 0);
      applyStimulus(1, 0, 128'd0, 1, 0, 0);
      checkOutput("fs_start", all_ones, 1, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1, 0, 128'd0, 0, 0, 0);
         checkOutput($sformatf("fs_dec%0d", k), all_ones - 128'(k), 1, 0, 0);
      end
      applyStimulus(0, 0, 128'd0, 0, 0, 0);
      checkOutput("rst_mid", 128'd0, 0, 0, 0);
      applyStimulus(1, 0, 128'd0, 0, 0, 0);
      checkOutput("rst_after", 128'd0, 0, 0, 0);

      // Expire with reload 4, then restart from EXPIRED: count 4 and done four decrements later.
      $display("[TB] expired restart sequence");
      applyStimulus(1, 1, 128'd4, 0, 0, 0);
      applyStimulus(1, 0, 128'd0, 1, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1, 0, 128'd0, 0, 0, 0);
      end
      checkOutput("ex_first", 128'd0, 0, 1, 1);
      applyStimulus(1, 0, 128'd0, 0, 0, 0);
      checkOutput("ex_idle", 128'd0, 0, 0, 1);
      applyStimulus(1, 0, 128'd0, 1, 0, 0);
      checkOutput("ex_restart", 128'd4, 1, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1, 0, 128'd0, 0, 0, 0);
         checkOutput($sformatf("ex_run%0d", k), 128'(4 - k), (k < 4), (k == 4), (k == 4));
      end

      // Auto-reload with reload register 0 must expire like a plain countdown.
      $display("[TB] auto-reload with zero reload");
      applyStimulus(1, 1, 128'd0, 0, 0, 1);
      applyStimulus(1, 0, 128'd0, 1, 0, 1);
      checkOutput("arz_start", 128'd0, 0, 1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
